// File: rtl/uart_tx_fifo.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding a serial UART transmitter (8N1 by default,
//            8E1 when the UART_TX_PARITY_EN macro is defined).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    en_i,
  input  logic [15:0]             prescale_i,
  input  logic [7:0]              data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    clr_i,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overrun_o
);

  localparam int c_AW    = $clog2(DEPTH);
  localparam int c_LVL_W = c_AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [7:0]         r_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               r_overrun;

  logic [15:0]        r_presc;
  logic [15:0]        r_baud_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_tx;

  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic               w_fifo_nempty;
  logic               w_bit_end;
  logic [2:0]         w_bit_cnt_next;
  logic               w_tx_next;

  // Acceptance depends only on the registered level, never on a same-cycle pop.
  assign ready_o       = (r_level < c_LVL_W'(DEPTH));
  assign w_push        = valid_i && ready_o;
  assign w_drop        = valid_i && !ready_o;
  assign w_fifo_nempty = (r_level != '0);
  assign w_bit_end     = (r_baud_cnt == r_presc);

  assign tx_o      = r_tx;
  assign busy_o    = (r_state != IDLE);
  assign level_o   = r_level;
  assign overrun_o = r_overrun;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_bit_cnt_next = r_bit_cnt;
    w_tx_next      = 1'b1;

    case (r_state)
      IDLE: begin
        if (en_i && w_fifo_nempty) begin
          w_pop        = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next   = DATA;
          w_bit_cnt_next = 3'd0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        // Back-to-back frames chain straight into the next start bit.
        if (w_bit_end) begin
          if (en_i && w_fifo_nempty) begin
            w_pop        = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Line level is registered from the upcoming state so tx_o is glitch-free.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_shift[w_bit_cnt_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = ^r_shift;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_presc    <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx      <= w_tx_next;
      r_bit_cnt <= w_bit_cnt_next;
      if (w_pop) begin
        r_presc    <= prescale_i;
        r_baud_cnt <= '0;
        r_shift    <= r_mem[r_rd_ptr];
      end else if (r_state != IDLE) begin
        r_baud_cnt <= w_bit_end ? 16'd0 : (r_baud_cnt + 16'd1);
      end
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scoreboard bench for uart_tx_fifo; a line monitor decodes frames
//            and compares them with the bytes the stimulus had accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic                   wb_clk_i   = 1'b0;
  logic                   wb_rst_i   = 1'b0;
  logic                   en_i       = 1'b0;
  logic [15:0]            prescale_i = 16'd0;
  logic [7:0]             data_i     = 8'd0;
  logic                   valid_i    = 1'b0;
  logic                   clr_i      = 1'b0;
  logic                   ready_o;
  logic                   tx_o;
  logic                   busy_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   overrun_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int unsigned prev_presc = 0;
  logic [7:0]  exp_q[$];
  int          start_cyc_q[$];
  int          lvl_q[$];

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .en_i       (en_i),
    .prescale_i (prescale_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .clr_i      (clr_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .level_o    (level_o),
    .overrun_o  (overrun_o)
  );

  // 40 MHz
  always #12.5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Decodes one frame whose start bit was seen on the current falling edge.
  // The bit period is the prescale presented on the cycle before tx fell.
  task automatic rx_frame();
    int         p;
    logic [NB-1:0] bits;
    logic [NB-1:0] want;
    logic [7:0] b;
    bit         shape_ok;
    bit         aborted;
    p        = int'(prev_presc) + 1;
    shape_ok = 1'b1;
    aborted  = 1'b0;
    bits     = '0;
    start_cyc_q.push_back(cyc);
    lvl_q.push_back(int'(level_o));
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < p; c++) begin
        if (k != 0 || c != 0) @(negedge wb_clk_i);
        if (wb_rst_i) begin
          aborted = 1'b1;
          break;
        end
        if (c == 0) bits[k] = tx_o;
        else if (tx_o !== bits[k]) shape_ok = 1'b0;
        if (busy_o !== 1'b1) shape_ok = 1'b0;
        prev_presc = prescale_i;
      end
      if (aborted) break;
    end
    if (aborted) return;
    check("frame_timing", 32'(shape_ok), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_frame: got 0x%0h, required no frame", bits);
    end else begin
      b = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
      want = {1'b1, ^b, b, 1'b0};
`else
      want = {1'b1, b, 1'b0};
`endif
      check("frame_bits", 32'(bits), 32'(want));
    end
  endtask

  initial begin : mon
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i) begin
        if (tx_o === 1'b0) rx_frame();
        else check("idle_busy", 32'(busy_o), 32'd0);
      end
      prev_presc = prescale_i;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    valid_i = 1'b1;
    data_i  = b;
    if (acc) exp_q.push_back(b);
    step(1);
    valid_i = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < max_cyc) begin
      step(1);
      n++;
    end
    check("drain_done", 32'(n < max_cyc), 32'd1);
  endtask

  initial begin : stim
    int  bc;
    int  n;
    int  mdl;
    bit  mdl_ovr;
    bit  drop;
    bit  clr;

    wb_rst_i = 1'b1;
    step(2);
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    wb_rst_i = 1'b0;
    step(1);

    // Single 0xA4 frame at 16 clocks per bit.
    prescale_i = 16'd15;
    en_i       = 1'b1;
    push(8'hA4, 1'b1);
    bc = 0;
    n  = 0;
    while (n < 1000) begin
      @(negedge wb_clk_i);
      if (busy_o) bc++;
      else if (bc > 0) break;
      n++;
    end
    check("busy_len", 32'(bc), 32'(NB * 16));
    step(1);

    prescale_i = 16'd2;
    push(8'h07, 1'b1);
    push(8'h03, 1'b1);
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    push(8'h80, 1'b1);
    push(8'h01, 1'b1);
    drain(3000);

    // Three queued frames must run back to back.
    en_i       = 1'b0;
    prescale_i = 16'd3;
    push(8'h55, 1'b1);
    push(8'hAA, 1'b1);
    push(8'h0F, 1'b1);
    check("lvl3", 32'(level_o), 32'd3);
    start_cyc_q.delete();
    lvl_q.delete();
    en_i = 1'b1;
    drain(1000);
    check("n_frames", 32'(start_cyc_q.size()), 32'd3);
    if (start_cyc_q.size() == 3) begin
      check("gap01", 32'(start_cyc_q[1] - start_cyc_q[0]), 32'(NB * 4));
      check("gap12", 32'(start_cyc_q[2] - start_cyc_q[1]), 32'(NB * 4));
      check("lvl_f0", 32'(lvl_q[0]), 32'd2);
      check("lvl_f1", 32'(lvl_q[1]), 32'd1);
      check("lvl_f2", 32'(lvl_q[2]), 32'd0);
    end

    // Overfill with the transmitter disabled.
    en_i       = 1'b0;
    prescale_i = 16'd1;
    mdl        = 0;
    for (int i = 0; i < 9; i++) begin
      push(8'h10 + 8'(i), mdl < DEPTH);
      if (mdl < DEPTH) mdl++;
    end
    check("full_level", 32'(level_o), 32'd8);
    check("full_ready", 32'(ready_o), 32'd0);
    check("full_overrun", 32'(overrun_o), 32'd1);
    valid_i = 1'b1;
    data_i  = 8'hEE;
    clr_i   = 1'b1;
    step(1);
    valid_i = 1'b0;
    clr_i   = 1'b0;
    check("ovr_set_wins", 32'(overrun_o), 32'd1);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;
    check("ovr_cleared", 32'(overrun_o), 32'd0);

    // Full FIFO: pop (enable rising) and push in the same cycle.
    en_i    = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h99;
    step(1);
    valid_i = 1'b0;
    check("popfull_level", 32'(level_o), 32'd7);
    check("popfull_overrun", 32'(overrun_o), 32'd1);
    check("popfull_ready", 32'(ready_o), 32'd1);
    drain(3000);
    clr_i = 1'b1;
    step(1);
    clr_i = 1'b0;

    // Reset in the middle of data bit 4.
    en_i       = 1'b0;
    prescale_i = 16'd15;
    push(8'h5A, 1'b1);
    push(8'hC3, 1'b1);
    push(8'h3C, 1'b1);
    en_i = 1'b1;
    n    = 0;
    while (tx_o !== 1'b0 && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("start_seen", 32'(n < 100), 32'd1);
    repeat (88) @(posedge wb_clk_i);
    #3;
    wb_rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("abort_tx", 32'(tx_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_level", 32'(level_o), 32'd0);
    step(3);
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_overrun", 32'(overrun_o), 32'd0);
    wb_rst_i = 1'b0;
    step(1);
    push(8'h41, 1'b1);
    drain(1000);

    // Randomized traffic: enable, prescale, clear and pushes all vary per cycle.
    mdl_ovr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      en_i       = ($urandom_range(0, 7) != 0);
      prescale_i = 16'($urandom_range(0, 5));
      clr        = ($urandom_range(0, 15) == 0);
      clr_i      = clr;
      valid_i    = ($urandom_range(0, 1) == 1);
      data_i     = 8'($urandom);
      drop       = 1'b0;
      if (valid_i) begin
        if (ready_o) exp_q.push_back(data_i);
        else drop = 1'b1;
      end
      step(1);
      mdl_ovr = drop ? 1'b1 : (clr ? 1'b0 : mdl_ovr);
      check("overrun_rand", 32'(overrun_o), 32'(mdl_ovr));
    end
    valid_i    = 1'b0;
    clr_i      = 1'b0;
    en_i       = 1'b1;
    prescale_i = 16'd2;
    drain(20000);
    step(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-002 SHALL have port wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en_i  input  1  transmitter enable; gates frame start only.
REQ-005 SHALL have port prescale_i  input  16  bit period = prescale_i+1 clocks.
REQ-006 SHALL have port data_i  input  8  byte to enqueue.
REQ-007 SHALL have port valid_i  input  1  enqueue request.
REQ-008 SHALL have port ready_o  output  1  FIFO can accept; high when level_o < DEPTH.
REQ-009 SHALL have port clr_i  input  1  synchronous clear of overrun_o.
REQ-010 SHALL have port tx_o  output  1  serial line, idle high, LSB first.
REQ-011 SHALL have port busy_o  output  1  high while a frame is on tx_o.
REQ-012 SHALL have port level_o  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have port overrun_o  output  1  sticky: write attempted while full.

Function
REQ-014 Push SHALL occur on a cycle with valid_i && ready_o; ready_o SHALL ignore same-cycle pop (full FIFO rejects push even if popping).
REQ-015 valid_i && !ready_o SHALL drop the byte and set overrun_o next cycle; overrun_o SHALL clear on clr_i; set SHALL win over simultaneous clr_i.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START SHALL occur when en_i && level_o != 0; pop and latch of prescale_i SHALL happen that same cycle; tx_o SHALL fall on the next cycle.
REQ-018 Each bit SHALL last exactly latched prescale+1 clocks; prescale_i changes mid-frame SHALL NOT affect the current frame.
REQ-019 DATA SHALL send 8 bits LSB first, then PARITY (when compiled in), then STOP (tx_o high, one bit period).
REQ-020 STOP -> START SHALL occur directly with no idle gap when en_i && FIFO non-empty at end of stop bit; else STOP -> IDLE.
REQ-021 busy_o SHALL be high from first start-bit cycle through last stop-bit cycle inclusive.
REQ-022 Deasserting en_i mid-frame SHALL complete the frame and start no further frame.
REQ-023 Simultaneous push and pop SHALL leave level_o unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 prescale_i = 0 SHALL yield one-clock bits.

Reset
REQ-025 On wb_rst_i: tx_o=1, busy_o=0, level_o=0, ready_o=1, overrun_o=0, FSM=IDLE, pointers and counters zero; FIFO contents discarded.
REQ-026 Reset asserted mid-frame SHALL force tx_o high immediately (asynchronously) and abort the frame.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state SHALL emit even parity over 8 data bits (frame 11 bit periods).
REQ-028 Macro UART_TX_PARITY_EN undefined: PARITY state SHALL be absent, DATA -> STOP directly (8N1, frame 10 bit periods).

Verification
REQ-029 Macro off, prescale_i=15, push 0xA4 -> tx_o low 16 clk, then 0,0,1,0,0,1,0,1 at 16 clk each, high 16 clk; busy_o high exactly 160 clk; monitor with 400 ns bit time at 40 MHz decodes 0xA4.
REQ-030 Push 9 bytes back-to-back with en_i=0, DEPTH=8 -> ready_o low after 8th, overrun_o=1, level_o=8; clr_i clears overrun_o.
REQ-031 en_i=1, prescale_i=3, push 0x55,0xAA,0x0F -> three frames contiguous (no idle cycle), 40 clk each, level_o decrements at each frame start.
REQ-032 Macro on, prescale_i=15, push 0x07 -> parity bit 1, frame 176 clk; push 0x03 -> parity bit 0.
REQ-033 Assert wb_rst_i during DATA bit 4 of a frame -> tx_o=1 same time step, busy_o=0, level_o=0; after release, pushed 0x41 transmits correctly.
REQ-034 FIFO full, push and pop same cycle (en_i rising) -> push rejected, overrun_o=1, level_o=7 next cycle.
